game_countdown_timer: RTL

Consumes the divided square wave produced by the game's clock divider (toggles every 250 000 `clk` cycles, so one rising edge every 10 ms at 50 MHz) and turns it into the round countdown timer. The block synchronises the slow wave into the `clk` domain and detects its rising edges. Each edge decrements a BCD seconds.centiseconds counter from `START_SEC`.00 to 00.00. It drives the scoreboard display and signals round end to the game FSM.

---
 rtl/fd_pkg.sv | 24 ++
 rtl/tick_sync_edge.sv | 31 +++
 rtl/game_countdown_timer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fd_pkg.sv
// Shared types and constants for the round countdown timer and related
// consumers of the divided clock wave.
package fd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_t;

  localparam logic [7:0] BCD_ZERO = 8'h00;
  localparam logic [7:0] CS_MAX   = 8'h99;

  // Two-digit BCD encoding of a value in 0..99; used to build reset/load constants.
  function automatic logic [7:0] to_bcd2(input int value);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(value / 10);
    ones = 4'(value % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/tick_sync_edge.sv
// Synchronises the slow divided wave into the clk domain and emits a
// registered one-cycle pulse for each rising edge.
module tick_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_in,
  output logic tick_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // NOTE: the chain and history flop reset to 1 so a wave already high at
  // reset release looks like "no change" rather than a fresh rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '1;
      hist_q     <= 1'b1;
      tick_pulse <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value of its predecessor, which is what forms the shift chain.
      sync_q     <= {sync_q[SYNC_STAGES-2:0], tick_in};
      hist_q     <= sync_q[SYNC_STAGES-1];
      tick_pulse <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

endmodule

// File: rtl/game_countdown_timer.sv
// Round countdown timer: counts a BCD seconds.centiseconds value down from
// START_SEC.00 to 00.00, one step per rising edge of the divided wave.
module game_countdown_timer
  import fd_pkg::*;
#(
  parameter int START_SEC   = 60,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] sec_bcd,
  output logic [7:0] cs_bcd,
  output logic       running,
  output logic       tick_seen,
  output logic       timeout
);

  localparam logic [7:0] START_BCD = to_bcd2(START_SEC);

  timer_state_t state_q, state_d;
  logic [7:0]   sec_d, cs_d;
  logic [7:0]   dec_sec, dec_cs;
  logic         cs_borrow;
  logic         timeout_d;
  logic         at_last;

  tick_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tick_sync_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_in   (tick_in),
    .tick_pulse(tick_seen)
  );

  // Digit-wise BCD decrement; centiseconds borrow from seconds at 00.
  always_comb begin
    dec_cs    = cs_bcd;
    dec_sec   = sec_bcd;
    cs_borrow = 1'b0;
    if (cs_bcd == BCD_ZERO) begin
      dec_cs    = CS_MAX;
      cs_borrow = 1'b1;
    end else if (cs_bcd[3:0] == 4'd0) begin
      dec_cs[3:0] = 4'd9;
      dec_cs[7:4] = cs_bcd[7:4] - 4'd1;
    end else begin
      dec_cs[3:0] = cs_bcd[3:0] - 4'd1;
    end
    if (cs_borrow) begin
      if (sec_bcd[3:0] == 4'd0) begin
        dec_sec[3:0] = 4'd9;
        dec_sec[7:4] = sec_bcd[7:4] - 4'd1;
      end else begin
        dec_sec[3:0] = sec_bcd[3:0] - 4'd1;
      end
    end
  end

  assign at_last = (sec_bcd == BCD_ZERO) && (cs_bcd == 8'h01);

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    sec_d     = sec_bcd;
    cs_d      = cs_bcd;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          sec_d   = START_BCD;
          cs_d    = BCD_ZERO;
        end
      end
      RUN: begin
        if (start) begin
          sec_d = START_BCD;
          cs_d  = BCD_ZERO;
        end else if (pause) begin
          state_d = PAUSED;
        end else if (tick_seen) begin
          if (at_last) begin
            state_d   = DONE;
            sec_d     = BCD_ZERO;
            cs_d      = BCD_ZERO;
            timeout_d = 1'b1;
          end else begin
            sec_d = dec_sec;
            cs_d  = dec_cs;
          end
        end
      end
      PAUSED: begin
        if (start) begin
          state_d = RUN;
          sec_d   = START_BCD;
          cs_d    = BCD_ZERO;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // running is registered from the next state so it changes on the same edge
  // as the counter and timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sec_bcd <= START_BCD;
      cs_bcd  <= BCD_ZERO;
      running <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_bcd <= sec_d;
      cs_bcd  <= cs_d;
      running <= (state_d == RUN);
      timeout <= timeout_d;
    end
  end

endmodule
